tlb_lookup_engine: RTL and testbench



---
 rtl/tlb_lookup_engine.sv | 190 +++++++++++++++++++
 tb/tb_tlb_lookup_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_lookup_engine.sv
// ---------------------------------------------------------------------------
// tlb_lookup_engine
//   Sequential lookup into a register-based, fully associative MIPS32-style
//   JTLB. One virtual address is accepted per request and entries are scanned
//   one per cycle, lowest index first. The response is a physical address or
//   one of miss/invalid/modified, plus an uncached flag. CP0 writes entries
//   through a dedicated write port.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid/o_req_ready request handshake (ready only in IDLE)
//   i_req_vaddr/asid/store  request payload
//   o_resp_valid/i_resp_ready response handshake
//   o_resp_paddr            {PFN, vaddr[11:0]}, 0 on any fault
//   o_resp_miss/invalid/modified  fault flags (at most one set)
//   o_resp_uncached         selected page C == 2 (0 on miss)
//   o_resp_index            matching entry, 0 on miss
//   i_wr_*                  entry write port (EntryHi / EntryLo0 / EntryLo1)
// ---------------------------------------------------------------------------
module tlb_lookup_engine #(
  parameter  int N_ENTRIES = 16,
  localparam int IW        = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // request
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [31:0]   i_req_vaddr,
  input  logic [7:0]    i_req_asid,
  input  logic          i_req_store,
  // response
  output logic          o_resp_valid,
  input  logic          i_resp_ready,
  output logic [31:0]   o_resp_paddr,
  output logic          o_resp_miss,
  output logic          o_resp_invalid,
  output logic          o_resp_modified,
  output logic          o_resp_uncached,
  output logic [IW-1:0] o_resp_index,
  // entry write port
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_index,
  input  logic [18:0]   i_wr_vpn2,
  input  logic [7:0]    i_wr_asid,
  input  logic          i_wr_g,
  input  logic [19:0]   i_wr_pfn0,
  input  logic [19:0]   i_wr_pfn1,
  input  logic [2:0]    i_wr_c0,
  input  logic [2:0]    i_wr_c1,
  input  logic          i_wr_d0,
  input  logic          i_wr_d1,
  input  logic          i_wr_v0,
  input  logic          i_wr_v1
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_ENTRIES - 1);

  tlb_entry_t             r_entry [N_ENTRIES];
  logic [N_ENTRIES-1:0]   r_present;

  state_t                 r_state;
  logic [IW-1:0]          r_idx;
  logic [31:0]            r_vaddr;
  logic [7:0]             r_asid;
  logic                   r_store;

  // Entry fields carry no reset; only the present bits matter after reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_entry[i_wr_index] <= '{vpn2: i_wr_vpn2, asid: i_wr_asid, g: i_wr_g,
                               pfn0: i_wr_pfn0, c0: i_wr_c0, d0: i_wr_d0, v0: i_wr_v0,
                               pfn1: i_wr_pfn1, c1: i_wr_c1, d1: i_wr_d1, v1: i_wr_v1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_present <= '0;
    else if (i_wr_en) r_present[i_wr_index] <= 1'b1;
  end

  // Compare of the entry under the scan pointer
  tlb_entry_t  w_ent;
  logic        w_hit;
  logic        w_odd;
  logic [19:0] w_pfn;
  logic [2:0]  w_c;
  logic        w_d;
  logic        w_v;
  logic        w_mod;

  always_comb begin
    w_ent = r_entry[r_idx];
    w_hit = r_present[r_idx] & (w_ent.vpn2 == r_vaddr[31:13]) &
            (w_ent.g | (w_ent.asid == r_asid));
    w_odd = r_vaddr[12];
    w_pfn = w_odd ? w_ent.pfn1 : w_ent.pfn0;
    w_c   = w_odd ? w_ent.c1   : w_ent.c0;
    w_d   = w_odd ? w_ent.d1   : w_ent.d0;
    w_v   = w_odd ? w_ent.v1   : w_ent.v0;
    // invalid outranks modified
    w_mod = w_v & ~w_d & r_store;
  end

  // o_req_ready is registered: it stays low for the first cycle after reset
  // and only rises once the FSM is settled in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_vaddr         <= '0;
      r_asid          <= '0;
      r_store         <= 1'b0;
      o_req_ready     <= 1'b0;
      o_resp_valid    <= 1'b0;
      o_resp_paddr    <= '0;
      o_resp_miss     <= 1'b0;
      o_resp_invalid  <= 1'b0;
      o_resp_modified <= 1'b0;
      o_resp_uncached <= 1'b0;
      o_resp_index    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          o_req_ready <= 1'b1;
          if (o_req_ready && i_req_valid) begin
            r_vaddr     <= i_req_vaddr;
            r_asid      <= i_req_asid;
            r_store     <= i_req_store;
            r_idx       <= '0;
            o_req_ready <= 1'b0;
            r_state     <= SEARCH;
          end
        end
        SEARCH: begin
          if (i_wr_en) begin
            // Contents changed under the scan: start over so the answer
            // reflects the post-write table.
            r_idx <= '0;
          end else if (w_hit) begin
            o_resp_valid    <= 1'b1;
            o_resp_miss     <= 1'b0;
            o_resp_invalid  <= ~w_v;
            o_resp_modified <= w_mod;
            o_resp_uncached <= (w_c == 3'd2);
            o_resp_paddr    <= (w_v && !w_mod) ? {w_pfn, r_vaddr[11:0]} : 32'd0;
            o_resp_index    <= r_idx;
            r_state         <= RESP;
          end else if (r_idx == LAST_IDX) begin
            o_resp_valid    <= 1'b1;
            o_resp_miss     <= 1'b1;
            o_resp_invalid  <= 1'b0;
            o_resp_modified <= 1'b0;
            o_resp_uncached <= 1'b0;
            o_resp_paddr    <= '0;
            o_resp_index    <= '0;
            r_state         <= RESP;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
            o_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_lookup_engine.sv
// Directed bench for tlb_lookup_engine (N_ENTRIES = 16).
module tb_tlb_lookup_engine;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_store;
  logic [31:0]   req_vaddr;
  logic [7:0]    req_asid;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_paddr;
  logic          resp_miss, resp_invalid, resp_modified, resp_uncached;
  logic [IW-1:0] resp_index;
  logic          wr_en, wr_g, wr_d0, wr_d1, wr_v0, wr_v1;
  logic [IW-1:0] wr_index;
  logic [18:0]   wr_vpn2;
  logic [7:0]    wr_asid;
  logic [19:0]   wr_pfn0, wr_pfn1;
  logic [2:0]    wr_c0, wr_c1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tlb_lookup_engine #(.N_ENTRIES(N)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_vaddr(req_vaddr), .i_req_asid(req_asid), .i_req_store(req_store),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_paddr(resp_paddr), .o_resp_miss(resp_miss),
    .o_resp_invalid(resp_invalid), .o_resp_modified(resp_modified),
    .o_resp_uncached(resp_uncached), .o_resp_index(resp_index),
    .i_wr_en(wr_en), .i_wr_index(wr_index), .i_wr_vpn2(wr_vpn2),
    .i_wr_asid(wr_asid), .i_wr_g(wr_g),
    .i_wr_pfn0(wr_pfn0), .i_wr_pfn1(wr_pfn1),
    .i_wr_c0(wr_c0), .i_wr_c1(wr_c1),
    .i_wr_d0(wr_d0), .i_wr_d1(wr_d1), .i_wr_v0(wr_v0), .i_wr_v1(wr_v1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Drive write fields at a negedge; the write lands on the next posedge.
  task automatic set_wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                        input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                        input logic d0, input logic v0, input logic [19:0] pfn1,
                        input logic [2:0] c1, input logic d1, input logic v1);
    wr_index = idx; wr_vpn2 = vpn2; wr_asid = asid; wr_g = g;
    wr_pfn0 = pfn0; wr_c0 = c0; wr_d0 = d0; wr_v0 = v0;
    wr_pfn1 = pfn1; wr_c1 = c1; wr_d1 = d1; wr_v1 = v1;
    wr_en = 1'b1;
  endtask

  task automatic wr_entry(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                          input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                          input logic d0, input logic v0, input logic [19:0] pfn1,
                          input logic [2:0] c1, input logic d1, input logic v1);
    @(negedge clk);
    set_wr(idx, vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Present a request for one cycle; returns at the negedge of cycle T+1.
  task automatic send(input string tag, input logic [31:0] va, input logic [7:0] asid,
                      input logic st);
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_vaddr = va; req_asid = asid; req_store = st; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Step negedges until resp_valid, continuing the cycle count from lat0.
  task automatic wait_resp(input string tag, input int lat0, input int exp_lat);
    int lat;
    lat = lat0;
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] pa, input logic miss,
                          input logic inv, input logic md, input logic unc, input logic [3:0] idx);
    chk({tag, ".valid"},    32'(resp_valid),    32'd1);
    chk({tag, ".paddr"},    resp_paddr,         pa);
    chk({tag, ".miss"},     32'(resp_miss),     32'(miss));
    chk({tag, ".invalid"},  32'(resp_invalid),  32'(inv));
    chk({tag, ".modified"}, 32'(resp_modified), 32'(md));
    chk({tag, ".uncached"}, 32'(resp_uncached), 32'(unc));
    chk({tag, ".index"},    32'(resp_index),    32'(idx));
  endtask

  task automatic take(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(resp_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input string tag, input logic [31:0] va, input logic [7:0] asid,
                        input logic st, input int exp_lat, input logic [31:0] pa,
                        input logic miss, input logic inv, input logic md,
                        input logic unc, input logic [3:0] idx);
    send(tag, va, asid, st);
    wait_resp(tag, 1, exp_lat);
    chk_resp(tag, pa, miss, inv, md, unc, idx);
    take(tag);
  endtask

  logic [31:0] held_pa;
  int          rose;

  initial begin
    rst = 1'b1; req_valid = 0; req_vaddr = 0; req_asid = 0; req_store = 0;
    resp_ready = 0; wr_en = 0; wr_index = 0; wr_vpn2 = 0; wr_asid = 0; wr_g = 0;
    wr_pfn0 = 0; wr_pfn1 = 0; wr_c0 = 0; wr_c1 = 0; wr_d0 = 0; wr_d1 = 0;
    wr_v0 = 0; wr_v1 = 0;
    repeat (2) @(negedge clk);
    chk("rst.req_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.paddr", resp_paddr, 32'd0);
    chk("rst.flags", {28'd0, resp_miss, resp_invalid, resp_modified, resp_uncached}, 32'd0);
    chk("rst.index", 32'(resp_index), 32'd0);

    // Empty table: full scan then miss at T+17.
    do_req("empty", 32'h0000_0000, 8'd0, 1'b0, 17, 32'd0, 1, 0, 0, 0, 4'd0);

    // Entry 5: vaddr 0x0040_3123 has VPN2 = 0x00201, odd page.
    wr_entry(4'd5, 19'h00201, 8'd3, 1'b0, 20'h00111, 3'd3, 1'b1, 1'b1,
             20'h1ABCD, 3'd3, 1'b1, 1'b1);
    do_req("hit5", 32'h0040_3123, 8'd3, 1'b0, 7, 32'h1ABC_D123, 0, 0, 0, 0, 4'd5);
    do_req("even5", 32'h0040_2ABC, 8'd3, 1'b0, 7, 32'h0011_1ABC, 0, 0, 0, 0, 4'd5);
    do_req("asid4", 32'h0040_3123, 8'd4, 1'b0, 17, 32'd0, 1, 0, 0, 0, 4'd0);

    // d1 = 0, store -> modified
    wr_entry(4'd5, 19'h00201, 8'd3, 1'b0, 20'h00111, 3'd3, 1'b1, 1'b1,
             20'h1ABCD, 3'd3, 1'b0, 1'b1);
    do_req("mod", 32'h0040_3123, 8'd3, 1'b1, 7, 32'd0, 0, 0, 1, 0, 4'd5);
    do_req("mod_load", 32'h0040_3123, 8'd3, 1'b0, 7, 32'h1ABC_D123, 0, 0, 0, 0, 4'd5);
    // v1 = 0 and d1 = 0, store -> invalid only
    wr_entry(4'd5, 19'h00201, 8'd3, 1'b0, 20'h00111, 3'd3, 1'b1, 1'b1,
             20'h1ABCD, 3'd3, 1'b0, 1'b0);
    do_req("inv", 32'h0040_3123, 8'd3, 1'b1, 7, 32'd0, 0, 1, 0, 0, 4'd5);
    // c1 = 2 -> uncached
    wr_entry(4'd5, 19'h00201, 8'd3, 1'b0, 20'h00111, 3'd3, 1'b1, 1'b1,
             20'h1ABCD, 3'd2, 1'b1, 1'b1);
    do_req("unc", 32'h0040_3123, 8'd3, 1'b0, 7, 32'h1ABC_D123, 0, 0, 0, 1, 4'd5);

    // Duplicate VPN2 0x12345 in 2 (global, other ASID) and 9: lowest wins.
    wr_entry(4'd2, 19'h12345, 8'd7, 1'b1, 20'h22222, 3'd3, 1'b1, 1'b1,
             20'h22223, 3'd3, 1'b1, 1'b1);
    wr_entry(4'd9, 19'h12345, 8'd0, 1'b0, 20'h99999, 3'd3, 1'b1, 1'b1,
             20'h9999A, 3'd3, 1'b1, 1'b1);
    do_req("dup", 32'h2468_A456, 8'd0, 1'b0, 4, 32'h2222_2456, 0, 0, 0, 0, 4'd2);

    // Entry 12 rewritten during the scan at cycle T+4: restart, new PFN.
    wr_entry(4'd12, 19'h70000, 8'd1, 1'b0, 20'h33333, 3'd3, 1'b1, 1'b1,
             20'h0, 3'd3, 1'b1, 1'b1);
    send("restart", 32'hE000_00F0, 8'd1, 1'b0);
    repeat (3) @(negedge clk);
    set_wr(4'd12, 19'h70000, 8'd1, 1'b0, 20'h44444, 3'd3, 1'b1, 1'b1,
           20'h0, 3'd3, 1'b1, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    wait_resp("restart", 5, 18);
    chk_resp("restart", 32'h4444_40F0, 0, 0, 0, 0, 4'd12);
    take("restart");

    // Backpressure: response held 5 cycles with req_valid high; a write in
    // RESP must not disturb the held response.
    send("hold", 32'h0040_3123, 8'd3, 1'b0);
    wait_resp("hold", 1, 7);
    held_pa = resp_paddr;
    chk("hold.paddr0", held_pa, 32'h1ABC_D123);
    req_valid = 1'b1;
    set_wr(4'd5, 19'h00201, 8'd3, 1'b0, 20'h00111, 3'd3, 1'b1, 1'b1,
           20'h0FFFF, 3'd3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      chk("hold.valid", 32'(resp_valid), 32'd1);
      chk("hold.req_ready", 32'(req_ready), 32'd0);
      chk("hold.paddr", resp_paddr, held_pa);
      chk("hold.uncached", 32'(resp_uncached), 32'd1);
    end
    req_valid = 1'b0;
    take("hold");
    do_req("post_hold", 32'h0040_3123, 8'd3, 1'b0, 7, 32'h0FFF_F123, 0, 0, 0, 0, 4'd5);

    // Reset mid-search: request discarded, table emptied.
    send("rstmid", 32'h0040_3123, 8'd3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.valid", 32'(resp_valid), 32'd0);
    chk("rstmid.ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid.ready", 32'(req_ready), 32'd1);
    rose = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) rose++;
    end
    chk("rstmid.no_resp", 32'(rose), 32'd0);
    do_req("rstmid_miss5", 32'h0040_3123, 8'd3, 1'b0, 17, 32'd0, 1, 0, 0, 0, 4'd0);
    do_req("rstmid_miss2", 32'h2468_A456, 8'd0, 1'b0, 17, 32'd0, 1, 0, 0, 0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
